// File: rtl/dmem_io_pkg.sv
// Shared address map, STAT bit positions and the address decoder for the
// data-memory / IO block.
package dmem_io_pkg;

    localparam logic [15:0] ADDR_LED  = 16'hFF00;
    localparam logic [15:0] ADDR_SW   = 16'hFF01;
    localparam logic [15:0] ADDR_CNT  = 16'hFF02;
    localparam logic [15:0] ADDR_CMP  = 16'hFF03;
    localparam logic [15:0] ADDR_STAT = 16'hFF04;
    localparam logic [15:0] ADDR_FIFO = 16'hFF05;

    localparam int STAT_MATCH = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_CNT,
        SEL_CMP,
        SEL_STAT,
        SEL_FIFO
    } sel_t;

    // RAM occupies the bottom 2^ram_aw words; everything else is a fixed register or unmapped.
    function automatic sel_t decode(input logic [15:0] addr, input int ram_aw);
        sel_t s;
        s = SEL_NONE;
        if ((addr >> ram_aw) == 16'd0) begin
            s = SEL_RAM;
        end else begin
            case (addr)
                ADDR_LED:  s = SEL_LED;
                ADDR_SW:   s = SEL_SW;
                ADDR_CNT:  s = SEL_CNT;
                ADDR_CMP:  s = SEL_CMP;
                ADDR_STAT: s = SEL_STAT;
                ADDR_FIFO: s = SEL_FIFO;
                default:   s = SEL_NONE;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/dmem_io_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head data reads 0 while empty and a
// push into an empty FIFO is not visible at the head until the next cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             push_drop,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop    = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign push_drop = push && !do_push;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dmem_io.sv
// Data memory plus memory-mapped IO: LED/switch ports, free-running counter
// with compare/match flag, and an output FIFO stream.
module dmem_io
    import dmem_io_pkg::*;
#(
    parameter int RAM_AW     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    output logic [15:0] memdout,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    sel_t        sel;
    logic [15:0] ram_mem [2**RAM_AW];
    logic [15:0] led_q, led_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cmp_q, cmp_d;
    logic        match_q, match_d;
    logic        ovf_q, ovf_d;
    logic [15:0] sw_meta_q, sw_meta_d;
    logic [15:0] sw_sync_q, sw_sync_d;
    logic [15:0] stat;
    logic        fifo_push, fifo_pop, fifo_drop, fifo_full, fifo_empty;

    assign sel       = decode(addr, RAM_AW);
    assign fifo_push = we && (sel == SEL_FIFO);
    assign fifo_pop  = out_ready && out_valid;
    assign out_valid = !fifo_empty;
    assign led       = led_q;

    always_ff @(posedge clk) begin
        if (we && (sel == SEL_RAM)) ram_mem[addr[RAM_AW-1:0]] <= wdata;
    end

    always_comb begin
        led_d     = led_q;
        cmp_d     = cmp_q;
        match_d   = match_q;
        ovf_d     = ovf_q;
        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
        cnt_d     = (we && (sel == SEL_CNT)) ? 16'd0 : cnt_q + 16'd1;
        if (we && (sel == SEL_LED)) led_d = wdata;
        if (we && (sel == SEL_CMP)) cmp_d = wdata;
        if (we && (sel == SEL_STAT) && wdata[STAT_MATCH]) match_d = 1'b0;
        if (we && (sel == SEL_STAT) && wdata[STAT_OVF])   ovf_d   = 1'b0;
        // Setting wins over a coincident W1C so no event is lost.
        if (cnt_d == cmp_q) match_d = 1'b1;
        if (fifo_drop)      ovf_d   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            cnt_q     <= '0;
            cmp_q     <= '0;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            led_q     <= led_d;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    always_comb begin
        stat             = 16'd0;
        stat[STAT_MATCH] = match_q;
        stat[STAT_FULL]  = fifo_full;
        stat[STAT_EMPTY] = fifo_empty;
        stat[STAT_OVF]   = ovf_q;
    end

    always_comb begin
        memdout = 16'd0;
        case (sel)
            SEL_RAM:  memdout = ram_mem[addr[RAM_AW-1:0]];
            SEL_LED:  memdout = led_q;
            SEL_SW:   memdout = sw_sync_q;
            SEL_CNT:  memdout = cnt_q;
            SEL_CMP:  memdout = cmp_q;
            SEL_STAT: memdout = stat;
            default:  memdout = 16'd0;
        endcase
    end

    sync_fifo #(
        .WIDTH(16),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(wdata),
        .pop      (fifo_pop),
        .head_data(out_data),
        .push_drop(fifo_drop),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_dmem_io.sv
// Self-checking bench for dmem_io: memory map, switch synchronizer, counter
// match, FIFO stream with scoreboard queue, and mid-stream reset.
module tb_dmem_io;

  localparam int DEPTH = 4;
  localparam logic [15:0] A_LED  = 16'hFF00;
  localparam logic [15:0] A_SW   = 16'hFF01;
  localparam logic [15:0] A_CNT  = 16'hFF02;
  localparam logic [15:0] A_CMP  = 16'hFF03;
  localparam logic [15:0] A_STAT = 16'hFF04;
  localparam logic [15:0] A_FIFO = 16'hFF05;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        we = 1'b0;
  logic [15:0] memdout;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_io #(.RAM_AW(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .memdout(memdout), .sw(sw), .led(led), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] v;
  logic [15:0] e;
  int m_count;
  logic m_ovf;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    addr = a; we = 1'b0;
    #1;
    d = memdout;
  endtask

  task automatic push_model(input logic [15:0] d);
    if (m_count < DEPTH) begin
      exp_q.push_back(d);
      m_count++;
    end else begin
      m_ovf = 1'b1;
    end
    wr(A_FIFO, d);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && budget < 20) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        m_count--;
        n_checks++;
        if (out_data !== e) $display("FAIL %s_data got=%h exp=%h", tag, out_data, e);
        else n_pass++;
      end
      tick(1);
      budget++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_timeout left=%0d exp=0", tag, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    rd(A_CNT, v);
    n_checks++; if (v !== 16'h0000) $display("FAIL rst_cnt got=%h exp=0000", v); else n_pass++;
    rd(A_LED, v);
    n_checks++; if (v !== 16'h0000 || led !== 16'h0000) $display("FAIL rst_led got=%h/%h exp=0000", v, led); else n_pass++;
    rd(A_CMP, v);
    n_checks++; if (v !== 16'h0000) $display("FAIL rst_cmp got=%h exp=0000", v); else n_pass++;
    rd(A_STAT, v);
    n_checks++; if (v !== 16'h0004) $display("FAIL rst_stat got=%h exp=0004", v); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) $display("FAIL rst_out got=%b/%h exp=0/0000", out_valid, out_data); else n_pass++;
    m_count = 0;
    m_ovf = 1'b0;
  endtask

  task automatic test_ram;
    wr(16'h0000, 16'hCAFE);
    wr(16'h0010, 16'h1234);
    rd(16'h0010, v);
    n_checks++; if (v !== 16'h1234) $display("FAIL ram_rd got=%h exp=1234", v); else n_pass++;
    wr(16'h00FF, 16'h5A5A);
    rd(16'h00FF, v);
    n_checks++; if (v !== 16'h5A5A) $display("FAIL ram_top got=%h exp=5a5a", v); else n_pass++;
    wr(16'h0200, 16'hDEAD);
    rd(16'h0200, v);
    n_checks++; if (v !== 16'h0000) $display("FAIL unmapped_rd got=%h exp=0000", v); else n_pass++;
    rd(16'h0000, v);
    n_checks++; if (v !== 16'hCAFE) $display("FAIL ram_alias got=%h exp=cafe", v); else n_pass++;
    wr(A_LED, 16'hBEEF);
    rd(A_LED, v);
    n_checks++; if (v !== 16'hBEEF || led !== 16'hBEEF) $display("FAIL led_rw got=%h/%h exp=beef", v, led); else n_pass++;
    rd(A_FIFO, v);
    n_checks++; if (v !== 16'h0000) $display("FAIL fifo_rd got=%h exp=0000", v); else n_pass++;
  endtask

  task automatic test_sw;
    sw = 16'hA5A5;
    tick(1);
    rd(A_SW, v);
    n_checks++; if (v !== 16'h0000) $display("FAIL sw_edge1 got=%h exp=0000", v); else n_pass++;
    tick(1);
    rd(A_SW, v);
    n_checks++; if (v !== 16'hA5A5) $display("FAIL sw_edge2 got=%h exp=a5a5", v); else n_pass++;
    tick(1);
    rd(A_SW, v);
    n_checks++; if (v !== 16'hA5A5) $display("FAIL sw_edge3 got=%h exp=a5a5", v); else n_pass++;
  endtask

  task automatic test_match;
    tick(10);
    wr(A_CMP, 16'h0005);
    wr(A_STAT, 16'h0001);
    wr(A_CNT, 16'h9999);
    rd(A_CNT, v);
    n_checks++; if (v !== 16'h0000) $display("FAIL cnt_clear got=%h exp=0000", v); else n_pass++;
    tick(4);
    rd(A_STAT, v);
    n_checks++; if (v[0] !== 1'b0) $display("FAIL match_early got=%b exp=0", v[0]); else n_pass++;
    rd(A_CNT, v);
    n_checks++; if (v !== 16'h0004) $display("FAIL cnt_4 got=%h exp=0004", v); else n_pass++;
    tick(1);
    rd(A_STAT, v);
    n_checks++; if (v[0] !== 1'b1) $display("FAIL match_set got=%b exp=1", v[0]); else n_pass++;
    wr(A_STAT, 16'h0001);
    rd(A_STAT, v);
    n_checks++; if (v[0] !== 1'b0) $display("FAIL match_w1c got=%b exp=0", v[0]); else n_pass++;
    // clear lands on the very edge of a new match: the match must survive
    wr(A_CNT, 16'h0000);
    tick(4);
    wr(A_STAT, 16'h0001);
    rd(A_STAT, v);
    n_checks++; if (v[0] !== 1'b1) $display("FAIL match_set_wins got=%b exp=1", v[0]); else n_pass++;
    wr(A_STAT, 16'h0001);
    rd(A_STAT, v);
    n_checks++; if (v !== 16'h0004) $display("FAIL match_final got=%h exp=0004", v); else n_pass++;
  endtask

  task automatic test_fifo_overflow;
    logic [15:0] vals [5];
    vals = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_model(vals[i]);
    e = {12'd0, m_ovf, (m_count == 0), (m_count == DEPTH), 1'b0};
    rd(A_STAT, v);
    n_checks++; if (v !== e || v !== 16'h000A) $display("FAIL ovf_stat got=%h exp=%h", v, e); else n_pass++;
    drain("ovf_drain");
    rd(A_STAT, v);
    n_checks++; if (v !== 16'h000C) $display("FAIL ovf_empty got=%h exp=000c", v); else n_pass++;
    wr(A_STAT, 16'h0008);
    m_ovf = 1'b0;
    rd(A_STAT, v);
    n_checks++; if (v !== 16'h0004) $display("FAIL ovf_w1c got=%h exp=0004", v); else n_pass++;
  endtask

  task automatic test_full_push_pop;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_model(16'h00A1 + 16'(i));
    addr = A_FIFO; wdata = 16'h0066; we = 1'b1; out_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    n_checks++; if (out_valid !== 1'b1 || out_data !== e) $display("FAIL fpp_head got=%b/%h exp=1/%h", out_valid, out_data, e); else n_pass++;
    exp_q.push_back(16'h0066);
    @(posedge clk);
    #1;
    we = 1'b0; out_ready = 1'b0;
    rd(A_STAT, v);
    n_checks++; if (v !== 16'h0002) $display("FAIL fpp_stat got=%h exp=0002", v); else n_pass++;
    drain("fpp_drain");
    rd(A_STAT, v);
    n_checks++; if (v !== 16'h0004) $display("FAIL fpp_empty got=%h exp=0004", v); else n_pass++;
  endtask

  task automatic test_empty_push_pop;
    out_ready = 1'b1;
    addr = A_FIFO; wdata = 16'h0077; we = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL epp_bypass got=%b exp=0", out_valid); else n_pass++;
    exp_q.push_back(16'h0077);
    @(posedge clk);
    #1;
    we = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (out_valid !== 1'b1 || out_data !== e) $display("FAIL epp_out got=%b/%h exp=1/%h", out_valid, out_data, e); else n_pass++;
    tick(1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL epp_popped got=%b exp=0", out_valid); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    push_model(16'h0001);
    push_model(16'h0002);
    wr(A_LED, 16'hFFFF);
    n_checks++; if (led !== 16'hFFFF || out_valid !== 1'b1) $display("FAIL pre_rst got=%h/%b exp=ffff/1", led, out_valid); else n_pass++;
    reset = 1'b1; addr = A_LED; wdata = 16'h1234; we = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; we = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    m_count = 0;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) $display("FAIL mrst_out got=%b/%h exp=0/0000", out_valid, out_data); else n_pass++;
    n_checks++; if (led !== 16'h0000) $display("FAIL mrst_led got=%h exp=0000", led); else n_pass++;
    rd(A_CNT, v);
    n_checks++; if (v !== 16'h0000) $display("FAIL mrst_cnt got=%h exp=0000", v); else n_pass++;
    rd(A_STAT, v);
    n_checks++; if (v !== 16'h0004) $display("FAIL mrst_stat got=%h exp=0004", v); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_sw();
    test_match();
    test_fifo_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_io.md
DMEM_IO -- requirements
Module: dmem_io

Interface
REQ-001 SHALL have parameter RAM_AW, default 8, RAM address width in words (2^RAM_AW x 16-bit RAM).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output FIFO depth in entries (power of two).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port addr, input, 16, CPU word address (datapath operand A).
REQ-006 SHALL have port wdata, input, 16, CPU write data (datapath operand B).
REQ-007 SHALL have port we, input, 1, write strobe from control unit.
REQ-008 SHALL have port memdout, output, 16, read data returned to datapath.
REQ-009 SHALL have port sw, input, 16, asynchronous board switches.
REQ-010 SHALL have port led, output, 16, LED register.
REQ-011 SHALL have ports out_data (output, 16), out_valid (output, 1) and out_ready (input, 1), forming the FIFO output stream.

Function
REQ-012 SHALL decode 0x0000..(2^RAM_AW-1) as RAM; 0xFF00 LED (R/W); 0xFF01 SW (R); 0xFF02 CNT (R, write clears); 0xFF03 CMP (R/W); 0xFF04 STAT (R, W1C); 0xFF05 FIFO push (W, reads 0).
REQ-013 SHALL make memdout combinational from addr in the same cycle; unmapped addresses read 0x0000 and ignore writes.
REQ-014 SHALL perform writes only at a clock edge with we=1; a read in the cycle after a write returns the new value.
REQ-015 SHALL pass sw through a 2-flop synchronizer; SW reads return the second stage (latency 2 cycles).
REQ-016 SHALL increment CNT by 1 each cycle, wrapping 0xFFFF->0x0000; a CNT write loads 0 and takes precedence over increment.
REQ-017 SHALL set sticky STAT[0] (MATCH) on the edge where CNT's next value equals CMP; a W1C write to bit0 in the same cycle as a new match leaves MATCH=1.
REQ-018 SHALL drive STAT[1]=full, STAT[2]=empty, STAT[3]=sticky OVF, STAT[15:4]=0; OVF is cleared by W1C on bit3.
REQ-019 SHALL accept a push when not full, or when full with a pop in the same cycle; otherwise it SHALL drop the data and set OVF.
REQ-020 SHALL assert out_valid whenever non-empty, hold out_data stable at the head until out_ready && out_valid (pop), and emit entries in FIFO order.
REQ-021 SHALL, on simultaneous push and pop when empty, hold the pushed word until the next cycle (no bypass; first out_valid one cycle after push).

Reset
REQ-022 SHALL clear led, CNT, CMP, MATCH, OVF, synchronizer stages and FIFO pointers on reset (out_valid=0, out_data=0, empty=1); RAM contents are not reset.
REQ-023 SHALL let reset take precedence over a coincident write or pop; mid-stream reset discards all FIFO entries.

Structure
REQ-024 SHALL put address map constants (ADDR_LED..ADDR_FIFO) and STAT bit indices in a shared package dmem_io_pkg.
REQ-025 SHALL implement the output queue as sub-module sync_fifo (parameterised width/depth, push/pop/full/empty).

Verification
REQ-026 SHALL test: write 0x1234 to 0x0010, then read 0x0010 -> memdout=0x1234; read 0x0200 -> 0x0000.
REQ-027 SHALL test: sw=0xA5A5 applied -> SW read is 0xA5A5 from the second edge onward, not before.
REQ-028 SHALL test: CMP=0x0005, CNT write at t0 -> MATCH=1 after 5 further edges; W1C bit0 -> STAT[0]=0.
REQ-029 SHALL test: out_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> STAT=0x000A (full, OVF); then out_ready=1 -> out_data 0x11,0x22,0x33,0x44 in order, then STAT[2]=1.
REQ-030 SHALL test: full FIFO with push 0x66 and pop in the same cycle -> no OVF, 0x66 emitted last.
REQ-031 SHALL test: reset asserted with FIFO holding 2 entries and led=0xFFFF -> next cycle out_valid=0, led=0x0000, CNT=0.
